// File: rtl/control_display_multiplexado.sv
`default_nettype none
// ============================================================================
// Module   : control_display_multiplexado
// Brief    : Multiplexed 7-segment scanner (common anode, up to 8 digits) with
//            frame snapshot, leading-zero blanking, PWM brightness and enable.
// Revision : 1.0 - initial release
// ============================================================================
module control_display_multiplexado #(
    parameter int NUM_DIGITOS  = 2,
    parameter int DIV_REFRESCO = 10000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     habilitar,
    input  logic [4*NUM_DIGITOS-1:0] datos,
    input  logic [NUM_DIGITOS-1:0]   puntos,
    input  logic                     suprimir_ceros,
    input  logic [3:0]               brillo,
    output logic [7:0]               anodo,
    output logic [6:0]               segmentos,
    output logic                     punto,
    output logic [2:0]               digito_activo,
    output logic                     fin_barrido
);

    localparam int                 c_pre_w      = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
    localparam logic [c_pre_w-1:0] c_pre_max    = c_pre_w'(DIV_REFRESCO - 1);
    localparam logic [c_pre_w-1:0] c_pre_uno    = c_pre_w'(1);
    localparam logic [2:0]         c_ult_digito = 3'(NUM_DIGITOS - 1);

    logic [c_pre_w-1:0]       r_presc;
    logic [3:0]               r_pwm;
    logic [4*NUM_DIGITOS-1:0] r_snap_datos;
    logic [NUM_DIGITOS-1:0]   r_snap_puntos;
    logic                     r_snap_supr;

    logic                     w_tick;
    logic                     w_wrap;
    logic                     w_pwm_on;
    logic                     w_ceros_arriba;
    logic [NUM_DIGITOS-1:0]   w_blank;
    logic [3:0]               w_nibble;
    logic                     w_blank_act;
    logic                     w_punto_act;
    logic [7:0]               w_anodo;
    logic [6:0]               w_seg_hex;

    assign w_tick   = habilitar && (r_presc == c_pre_max);
    assign w_wrap   = w_tick && (digito_activo == c_ult_digito);
    assign w_pwm_on = (r_pwm <= brillo);

    // Walk down from the most significant digit; digit 0 is never blanked.
    always_comb begin
        w_blank        = '0;
        w_ceros_arriba = r_snap_supr;
        for (int i = NUM_DIGITOS - 1; i >= 1; i--) begin
            w_ceros_arriba = w_ceros_arriba && (r_snap_datos[4*i +: 4] == 4'h0);
            w_blank[i]     = w_ceros_arriba;
        end
    end

    always_comb begin
        w_nibble    = 4'h0;
        w_blank_act = 1'b0;
        w_punto_act = 1'b0;
        w_anodo     = 8'hFF;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (digito_activo == 3'(i)) begin
                w_nibble    = r_snap_datos[4*i +: 4];
                w_blank_act = w_blank[i];
                w_punto_act = r_snap_puntos[i];
                w_anodo[i]  = ~w_pwm_on;
            end
        end
    end

    // Active-low {g,f,e,d,c,b,a}
    always_comb begin
        w_seg_hex = 7'h7F;
        case (w_nibble)
            4'h0: w_seg_hex = 7'b1000000;
            4'h1: w_seg_hex = 7'b1111001;
            4'h2: w_seg_hex = 7'b0100100;
            4'h3: w_seg_hex = 7'b0110000;
            4'h4: w_seg_hex = 7'b0011001;
            4'h5: w_seg_hex = 7'b0010010;
            4'h6: w_seg_hex = 7'b0000010;
            4'h7: w_seg_hex = 7'b1111000;
            4'h8: w_seg_hex = 7'b0000000;
            4'h9: w_seg_hex = 7'b0010000;
            4'hA: w_seg_hex = 7'b0001000;
            4'hB: w_seg_hex = 7'b0000011;
            4'hC: w_seg_hex = 7'b1000110;
            4'hD: w_seg_hex = 7'b0100001;
            4'hE: w_seg_hex = 7'b0000110;
            4'hF: w_seg_hex = 7'b0001110;
            default: w_seg_hex = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_pwm         <= 4'd0;
            r_snap_datos  <= '0;
            r_snap_puntos <= '0;
            r_snap_supr   <= 1'b0;
            digito_activo <= 3'd0;
            fin_barrido   <= 1'b0;
            anodo         <= 8'hFF;
            segmentos     <= 7'h7F;
            punto         <= 1'b1;
        end else begin
            r_pwm       <= r_pwm + 4'd1;
            fin_barrido <= w_wrap;

            if (habilitar) begin
                r_presc   <= (r_presc == c_pre_max) ? '0 : r_presc + c_pre_uno;
                anodo     <= w_anodo;
                segmentos <= w_blank_act ? 7'h7F : w_seg_hex;
                punto     <= ~w_punto_act;
            end else begin
                anodo     <= 8'hFF;
                segmentos <= 7'h7F;
                punto     <= 1'b1;
            end

            if (w_tick) begin
                digito_activo <= (digito_activo == c_ult_digito) ? 3'd0 : digito_activo + 3'd1;
            end

            // Capture on the edge that starts a new frame so a frame never mixes data.
            if (w_wrap) begin
                r_snap_datos  <= datos;
                r_snap_puntos <= puntos;
                r_snap_supr   <= suprimir_ceros;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_display_multiplexado.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_display_multiplexado
// Brief    : Self-checking bench for the multiplexed display scanner (3 digits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_display_multiplexado;

    localparam int c_nd  = 3;
    localparam int c_div = 4;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       pt;
        logic [2:0] idx;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              habilitar = 1'b1;
    logic [4*c_nd-1:0] datos = 12'h123;
    logic [c_nd-1:0]   puntos = 3'b000;
    logic              suprimir_ceros = 1'b0;
    logic [3:0]        brillo = 4'd15;
    logic [7:0]        anodo;
    logic [6:0]        segmentos;
    logic              punto;
    logic [2:0]        digito_activo;
    logic              fin_barrido;

    int   vectors = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    exp_t e;
    logic [7:0] prev_an = 8'hFF;
    logic prev_fin = 1'b0;
    int   cyc = 0;
    int   last_fin = -1;
    int   cnt;
    int   br_tab[3]  = '{3, 0, 7};
    int   duty_tab[3] = '{12, 3, 24};

    control_display_multiplexado #(
        .NUM_DIGITOS (c_nd),
        .DIV_REFRESCO(c_div)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .habilitar     (habilitar),
        .datos         (datos),
        .puntos        (puntos),
        .suprimir_ceros(suprimir_ceros),
        .brillo        (brillo),
        .anodo         (anodo),
        .segmentos     (segmentos),
        .punto         (punto),
        .digito_activo (digito_activo),
        .fin_barrido   (fin_barrido)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // p[i] = 1 requests the point on digit i (pin is active-low)
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [2:0] p);
        exp_q.push_back({8'hFE, s0, ~p[0], 3'd0});
        exp_q.push_back({8'hFD, s1, ~p[1], 3'd1});
        exp_q.push_back({8'hFB, s2, ~p[2], 3'd2});
    endtask

    task automatic wait_fin();
        bit ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (fin_barrido) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL wait_fin: no fin_barrido within 100 cycles, expected a pulse");
        end
    endtask

    task automatic wait_idx(input logic [2:0] v);
        bit ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (digito_activo == v) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL wait_idx: digito_activo=%0d after 100 cycles, expected %0d", digito_activo, v);
        end
    endtask

    // Monitor: every newly presented digit is one scoreboard transaction
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (anodo != prev_an && anodo != 8'hFF) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL scan_unexpected: anodo=%h segmentos=%h punto=%b, expected no new digit",
                                 anodo, segmentos, punto);
                    end else begin
                        e = exp_q.pop_front();
                        if ({anodo, segmentos, punto, digito_activo} !== e) begin
                            errors++;
                            $display("FAIL scan: got an=%h seg=%h pt=%b idx=%0d expected an=%h seg=%h pt=%b idx=%0d",
                                     anodo, segmentos, punto, digito_activo, e.an, e.seg, e.pt, e.idx);
                        end
                    end
                end
                if (fin_barrido) begin
                    if (last_fin >= 0) begin
                        vectors++;
                        if ((cyc - last_fin) != c_nd * c_div || prev_fin) begin
                            errors++;
                            $display("FAIL fin_period: got %0d cycles (prev_high=%b) expected %0d",
                                     cyc - last_fin, prev_fin, c_nd * c_div);
                        end
                    end
                    last_fin = cyc;
                end
            end
            prev_an  = anodo;
            prev_fin = fin_barrido;
        end
    end

    initial begin
        // Before the first snapshot every digit shows "0"; frame 1 takes 12'h123.
        push_frame(7'h40, 7'h40, 7'h40, 3'b000);
        push_frame(7'h30, 7'h24, 7'h79, 3'b000);
        mon_en = 1'b1;

        @(negedge clk);
        check("reset_state", {12'h0, anodo, segmentos, punto, digito_activo, fin_barrido},
              {12'h0, 8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0});
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("first_tick_pre", 32'(digito_activo), 32'd0);
        @(negedge clk);
        check("first_tick", 32'(digito_activo), 32'd1);

        wait_fin(); wait_idx(3'd1);
        datos = 12'h456; puntos = 3'b010;
        push_frame(7'h02, 7'h12, 7'h19, 3'b010);

        wait_fin(); wait_idx(3'd1);
        datos = 12'h005; suprimir_ceros = 1'b1; puntos = 3'b000;
        push_frame(7'h12, 7'h7F, 7'h7F, 3'b000);

        wait_fin(); wait_idx(3'd1);
        datos = 12'h000;
        push_frame(7'h40, 7'h7F, 7'h7F, 3'b000);

        wait_fin(); wait_idx(3'd1);
        datos = 12'h0A0; puntos = 3'b100;
        push_frame(7'h40, 7'h08, 7'h7F, 3'b100);

        wait_fin(); wait_idx(3'd1);
        datos = 12'hBCF; suprimir_ceros = 1'b0; puntos = 3'b001;
        push_frame(7'h0E, 7'h46, 7'h03, 3'b001);

        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        for (int k = 0; k < 3; k++) begin
            brillo = 4'(br_tab[k]);
            repeat (2) @(negedge clk);
            cnt = 0;
            repeat (48) begin
                @(negedge clk);
                if (anodo != 8'hFF) cnt++;
            end
            check("pwm_duty_48clk", 32'(cnt), 32'(duty_tab[k]));
        end
        brillo = 4'd15;

        // Disable one clock into digit 1's slot, leaving 3 prescaler counts.
        wait_fin(); wait_idx(3'd1);
        @(posedge clk); #1;
        habilitar = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("disable_blank", {16'h0, anodo, segmentos, punto}, {16'h0, 8'hFF, 7'h7F, 1'b1});
        check("disable_freeze_idx", 32'(digito_activo), 32'd1);
        check("disable_no_fin", 32'(fin_barrido), 32'd0);
        habilitar = 1'b1;
        @(negedge clk);
        check("reenable_display", {17'h0, anodo, segmentos}, {17'h0, 8'hFD, 7'h46});
        @(negedge clk);
        check("reenable_hold_idx", 32'(digito_activo), 32'd1);
        @(negedge clk);
        check("reenable_tick", 32'(digito_activo), 32'd2);

        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", {12'h0, anodo, segmentos, punto, digito_activo, fin_barrido},
              {12'h0, 8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_snapshot", {16'h0, anodo, segmentos, punto}, {16'h0, 8'hFE, 7'h40, 1'b1});
        repeat (2) @(negedge clk);
        check("post_reset_pre_tick", 32'(digito_activo), 32'd0);
        @(negedge clk);
        check("post_reset_tick", 32'(digito_activo), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
